// File: rtl/button_conditioner.sv
// Front-end conditioning for the processor's push buttons and slide switches:
// two-flop synchronizers on every input, plus debounce and press-edge pulses on the buttons.
module button_conditioner #(
    parameter int DEBOUNCE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       LoadA_n,
    input  logic       LoadB_n,
    input  logic       Execute_n,
    input  logic [7:0] Din_raw,
    input  logic [2:0] F_raw,
    input  logic [1:0] R_raw,
    output logic       LoadA,
    output logic       LoadB,
    output logic       Execute,
    output logic [7:0] Din,
    output logic [2:0] F,
    output logic [1:0] R,
    output logic [2:0] Held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    // Channel order everywhere: bit 0 = LoadA, bit 1 = LoadB, bit 2 = Execute.
    logic [2:0]       raw_n;
    logic [2:0]       btn_s1;
    logic [2:0]       btn_s2;
    logic [2:0]       pressed;
    logic [2:0]       stable;
    logic [2:0]       pulse;
    logic [CNT_W-1:0] cnt [3];

    logic [7:0] din_s1;
    logic [7:0] din_s2;
    logic [2:0] f_s1;
    logic [2:0] f_s2;
    logic [1:0] r_s1;
    logic [1:0] r_s2;

    assign raw_n   = {Execute_n, LoadB_n, LoadA_n};
    assign pressed = ~btn_s2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // Synchronizers reload "released" so a button held through reset
            // is seen as a fresh press once reset drops.
            btn_s1 <= 3'b111;
            btn_s2 <= 3'b111;
            stable <= 3'b000;
            pulse  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_s1 <= raw_n;
            btn_s2 <= btn_s1;
            for (int i = 0; i < 3; i++) begin
                pulse[i] <= 1'b0;
                if (pressed[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // Only the 0->1 acceptance fires a pulse; release is silent.
                    stable[i] <= pressed[i];
                    pulse[i]  <= pressed[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            din_s1 <= '0;
            din_s2 <= '0;
            f_s1   <= '0;
            f_s2   <= '0;
            r_s1   <= '0;
            r_s2   <= '0;
        end else begin
            din_s1 <= Din_raw;
            din_s2 <= din_s1;
            f_s1   <= F_raw;
            f_s2   <= f_s1;
            r_s1   <= R_raw;
            r_s2   <= r_s1;
        end
    end

    assign LoadA   = pulse[0];
    assign LoadB   = pulse[1];
    assign Execute = pulse[2];
    assign Held    = stable;
    assign Din     = din_s2;
    assign F       = f_s2;
    assign R       = r_s2;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=4): expected pulses are queued
// as {cycle, channel mask} and a negedge monitor pops one per observed pulse.
module tb_button_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic       LoadA_n, LoadB_n, Execute_n;
    logic [7:0] Din_raw;
    logic [2:0] F_raw;
    logic [1:0] R_raw;
    logic       LoadA, LoadB, Execute;
    logic [7:0] Din;
    logic [2:0] F;
    logic [1:0] R;
    logic [2:0] Held;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // {cycle count at which the pulse is visible, pulse mask {Execute, LoadB, LoadA}}
    logic [34:0] exp_q[$];

    button_conditioner #(.DEBOUNCE(D), .CNT_W(4)) dut (
        .Clk(clk), .Reset(Reset),
        .LoadA_n(LoadA_n), .LoadB_n(LoadB_n), .Execute_n(Execute_n),
        .Din_raw(Din_raw), .F_raw(F_raw), .R_raw(R_raw),
        .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
        .Din(Din), .F(F), .R(R), .Held(Held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [2:0]  vec;
        logic [34:0] e;
        vec = {Execute, LoadB, LoadA};
        if (vec != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, vec}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_mask", {29'd0, vec}, {29'd0, e[2:0]});
                check("pulse_cycle", cyc, e[34:3]);
            end
        end
    end

    task automatic set_buttons(input logic [2:0] pressed_mask);
        {Execute_n, LoadB_n, LoadA_n} = ~pressed_mask;
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Press the masked buttons cleanly, release after 'hold' cycles, watch Held every cycle.
    task automatic press_release(input logic [2:0] mask, input int hold, input int tail);
        int c;
        c = cyc;
        set_buttons(mask);
        exp_q.push_back({32'(c + D + 2), mask});
        for (int i = 1; i <= hold + tail; i++) begin
            @(negedge clk);
            check("held", {29'd0, Held}, (i >= D + 2 && i < hold + D + 2) ? {29'd0, mask} : 32'd0);
            if (i == hold) set_buttons(3'b000);
        end
        check_drained("missing_pulse");
    endtask

    initial begin
        int c;
        Reset     = 1'b1;
        set_buttons(3'b000);
        Din_raw   = 8'hA5;
        F_raw     = 3'b101;
        R_raw     = 2'b10;

        // Reset state and switch synchronizer latency
        repeat (3) @(negedge clk);
        check("rst_pulses", {29'd0, Execute, LoadB, LoadA}, 32'd0);
        check("rst_held", {29'd0, Held}, 32'd0);
        check("rst_din", {24'd0, Din}, 32'd0);
        check("rst_f", {29'd0, F}, 32'd0);
        check("rst_r", {30'd0, R}, 32'd0);
        Reset = 1'b0;
        @(negedge clk);
        check("din_edge0", {24'd0, Din}, 32'd0);
        check("f_edge0", {29'd0, F}, 32'd0);
        check("r_edge0", {30'd0, R}, 32'd0);
        @(negedge clk);
        check("din_edge1", {24'd0, Din}, 32'hA5);
        check("f_edge1", {29'd0, F}, 32'd5);
        check("r_edge1", {30'd0, R}, 32'd2);

        // Clean press on LoadA
        press_release(3'b001, 20, 10);

        // Bounce on Execute: low 3, high 1, low 3, high -> never accepted
        for (int i = 0; i < 14; i++) begin
            Execute_n = !((i < 3) || (i >= 4 && i < 7));
            @(negedge clk);
            check("bounce_held", {29'd0, Held}, 32'd0);
        end
        check_drained("bounce_queue");

        // Long hold on LoadB, silent release
        press_release(3'b010, 50, 10);

        // Simultaneous LoadA + Execute
        press_release(3'b101, 10, 10);

        // Reset pulse at edge 3 of a LoadA press restarts debounce
        c = cyc;
        LoadA_n = 1'b0;
        exp_q.push_back({32'(c + 10), 3'b001});
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 3) Reset = 1'b1;
            if (i == 4) Reset = 1'b0;
            check("rst_mid_held", {29'd0, Held}, (i >= 10 && i < 26) ? 32'd1 : 32'd0);
            if (i == 20) LoadA_n = 1'b1;
        end
        check_drained("rst_mid_queue");

        // Button held through reset is a fresh press once reset drops
        c = cyc;
        Reset   = 1'b1;
        LoadA_n = 1'b0;
        exp_q.push_back({32'(c + 8), 3'b001});
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 2) Reset = 1'b0;
            check("rst_hold_held", {29'd0, Held}, (i >= 8 && i < 18) ? 32'd1 : 32'd0);
            if (i == 12) LoadA_n = 1'b1;
        end
        check_drained("rst_hold_queue");

        // Switch change mid-run: still two-edge latency, no latching
        Din_raw = 8'h3C;
        F_raw   = 3'b010;
        R_raw   = 2'b01;
        @(negedge clk);
        check("din_old", {24'd0, Din}, 32'hA5);
        check("f_old", {29'd0, F}, 32'd5);
        check("r_old", {30'd0, R}, 32'd2);
        @(negedge clk);
        check("din_new", {24'd0, Din}, 32'h3C);
        check("f_new", {29'd0, F}, 32'd2);
        check("r_new", {30'd0, R}, 32'd1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE, default 50000: consecutive cycles a synchronized button level must differ from the debounced level before it is accepted; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16: width of each debounce counter; CNT_W SHALL be large enough to hold DEBOUNCE-1.
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 LoadA_n  input  1  raw push button, active-low, asynchronous to Clk, may bounce.
REQ-006 LoadB_n  input  1  raw push button, same properties as LoadA_n.
REQ-007 Execute_n  input  1  raw push button, same properties as LoadA_n.
REQ-008 Din_raw  input  8  raw slide switches for the data operand, asynchronous.
REQ-009 F_raw  input  3  raw slide switches for function select, asynchronous.
REQ-010 R_raw  input  2  raw slide switches for routing select, asynchronous.
REQ-011 LoadA  output  1  one-cycle pulse per accepted LoadA press, for the processor's LoadA input.
REQ-012 LoadB  output  1  one-cycle pulse per accepted LoadB press.
REQ-013 Execute  output  1  one-cycle pulse per accepted Execute press.
REQ-014 Din  output  8  Din_raw after two-flop synchronization.
REQ-015 F  output  3  F_raw after two-flop synchronization.
REQ-016 R  output  2  R_raw after two-flop synchronization.
REQ-017 Held  output  3  debounced pressed levels {Execute, LoadB, LoadA}, active-high, for debug LEDs.

Function
REQ-018 Each button channel SHALL pass its raw input through two flops (s1, s2); pressed = ~s2.
REQ-019 Each channel SHALL hold a debounced level `stable` and a counter `cnt`.
REQ-020 If pressed == stable, cnt SHALL be cleared to 0 on that edge.
REQ-021 If pressed != stable and cnt < DEBOUNCE-1, cnt SHALL increment by 1.
REQ-022 If pressed != stable and cnt == DEBOUNCE-1, stable SHALL take the value of pressed and cnt SHALL clear to 0.
REQ-023 Any bounce that returns pressed to stable before acceptance SHALL clear cnt, so acceptance requires DEBOUNCE uninterrupted differing cycles.
REQ-024 A channel's pulse output SHALL be registered and SHALL be high for exactly one cycle, on the same edge where stable changes 0->1.
REQ-025 A 1->0 change of stable (release) SHALL produce no pulse.
REQ-026 Press-to-pulse latency: raw low first sampled at edge 0 -> pulse visible after edge DEBOUNCE+1 and low again after edge DEBOUNCE+2.
REQ-027 A button held indefinitely SHALL produce exactly one pulse.
REQ-028 Channels are independent; simultaneous presses SHALL produce pulses in the same cycle with no priority or suppression.
REQ-029 Held[i] SHALL equal channel i's stable level.
REQ-030 Din, F and R SHALL each be a plain two-flop synchronizer with 2-edge latency and no debounce or latching.

Reset
REQ-031 While Reset is high at a rising edge: button s1/s2 flops SHALL load 1 (released), and stable, cnt, LoadA, LoadB, Execute, Held, and all Din/F/R synchronizer flops SHALL load 0.
REQ-032 Reset mid-debounce SHALL discard the partial count; no pulse may result from pre-reset activity.
REQ-033 A button held through reset deassertion SHALL be treated as a fresh press and pulse DEBOUNCE+1 edges after the first post-reset edge that samples it low.

Verification (DEBOUNCE=4)
REQ-034 Clean press: LoadA_n 1->0 sampled at edge 0 and held for 20 cycles -> LoadA=1 only after edge 5, Held[0]=1 from edge 5, no other pulse.
REQ-035 Bounce: Execute_n low for 3 cycles, high for 1, low for 3, then high -> Execute never asserted, Held[2] stays 0.
REQ-036 Hold then release: LoadB_n low for 50 cycles, then high for 10 -> exactly one LoadB pulse; Held[1] returns to 0 four cycles after s2 goes high; no pulse on release.
REQ-037 Simultaneous: LoadA_n and Execute_n fall on the same edge -> LoadA and Execute both high in the same single cycle.
REQ-038 Reset mid-count: LoadA_n low, Reset pulsed high for 1 cycle at edge 3 while LoadA_n stays low -> no pulse before reset; one pulse after edge 5 counted from the first post-reset sampling edge.
REQ-039 Switches: Din_raw=8'hA5, F_raw=3'b101, R_raw=2'b10 applied before edge 0 -> Din=8'hA5, F=3'b101, R=2'b10 visible after edge 1; all 0 during reset.
